inport_buffer: RTL and testbench

Buffered input-port front end sitting directly upstream of the datapath's input port: it captures words from an external device on an asynchronous strobe, queues them in a small FIFO, and presents the head word on `InPortData` for the `in` instruction. The control unit pops one word per executed `in`. The block also reports occupancy and a sticky overflow flag, so software can poll status instead of losing back-to-back device writes.

---
 rtl/inport_buffer.sv | 127 ++++++++++++
 tb/tb_inport_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inport_buffer.sv
// inport_buffer
//   Input-port front end for the datapath. A device writes words using an
//   asynchronous strobe. Each word is synchronized and queued in a small FIFO,
//   and the head word is presented on InPortData for the `in` instruction.
//
// Ports
//   clk         system clock; all state updates on its rising edge
//   clr         synchronous active-high reset
//   dev_data    device word; held stable for 3 clk edges after the strobe rises
//   dev_strobe  asynchronous write strobe; each 0->1 transition is one write
//   cpu_pop     one-cycle pulse when the `in` instruction consumes InPortData
//   ovf_clr     clears the sticky overflow flag
//   InPortData  head word when non-empty, otherwise the last popped word
//   data_avail  FIFO holds at least one word
//   full        FIFO holds DEPTH words
//   count       number of queued words, 0..DEPTH
//   overflow    sticky: a device write was dropped because the FIFO was full
module inport_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] dev_data,
  input  logic                  dev_strobe,
  input  logic                  cpu_pop,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] InPortData,
  output logic                  data_avail,
  output logic                  full,
  output logic [CW-1:0]         count,
  output logic                  overflow
);

  localparam int PW = $clog2(DEPTH);

  // Strobe synchronizer (s1, s2) and edge register (s3)
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  // FIFO control state
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic                  ovf_q, ovf_d;

  // Storage; contents are don't-care after reset, so it has no reset
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic push_req;
  logic push_ok;
  logic pop_ok;
  logic drop;

  always_comb begin
    s1_d     = dev_strobe;
    s2_d     = s1_q;
    s3_d     = s2_q;

    push_req = s2_q & ~s3_q;
    // An empty FIFO ignores pops, even when a push lands in the same cycle.
    pop_ok   = cpu_pop & (count_q != '0);
    // A full FIFO still accepts a push if a word leaves in the same cycle.
    push_ok  = push_req & ((count_q < CW'(DEPTH)) | cpu_pop);
    drop     = push_req & ~push_ok;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    ovf_d    = ovf_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      last_d   = mem_q[rd_ptr_q];
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as ovf_clr leaves the flag set.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      s3_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
    end
  end

  // When the FIFO is full, a push and a pop share the same slot. The popped
  // word is copied into last_q from the old contents on this same edge.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= dev_data;
  end

  assign InPortData = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign data_avail = (count_q != '0);
  assign full       = (count_q == CW'(DEPTH));
  assign count      = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_inport_buffer.sv
module tb_inport_buffer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] dev_data;
  logic        dev_strobe;
  logic        cpu_pop;
  logic        ovf_clr;
  logic [31:0] InPortData;
  logic        data_avail;
  logic        full;
  logic [2:0]  count;
  logic        overflow;

  inport_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .dev_data   (dev_data),
    .dev_strobe (dev_strobe),
    .cpu_pop    (cpu_pop),
    .ovf_clr    (ovf_clr),
    .InPortData (InPortData),
    .data_avail (data_avail),
    .full       (full),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop must present the oldest outstanding word.
  always @(negedge clk) begin
    if (cpu_pop && data_avail) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_read: got 0x%08h with no word expected", InPortData);
      end else begin
        check("pop_read", InPortData, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Full write: strobe high for 3 edges (push lands on the 3rd), then low 2.
  task automatic dev_write(input logic [31:0] d, input bit accepted);
    dev_data   = d;
    dev_strobe = 1'b1;
    if (accepted) exp_q.push_back(d);
    ticks(3);
    dev_strobe = 1'b0;
    ticks(2);
  endtask

  task automatic pop();
    cpu_pop = 1'b1;
    tick();
    cpu_pop = 1'b0;
  endtask

  // Raise the strobe and assert cpu_pop (or ovf_clr) on the push edge.
  task automatic write_with(input logic [31:0] d, input bit accepted, input bit do_pop, input bit do_oclr);
    dev_data   = d;
    dev_strobe = 1'b1;
    if (accepted) exp_q.push_back(d);
    ticks(2);
    cpu_pop = do_pop;
    ovf_clr = do_oclr;
    tick();
    cpu_pop    = 1'b0;
    ovf_clr    = 1'b0;
    dev_strobe = 1'b0;
    ticks(2);
  endtask

  initial begin
    clr        = 1'b1;
    dev_data   = '0;
    dev_strobe = 1'b0;
    cpu_pop    = 1'b0;
    ovf_clr    = 1'b0;
    ticks(2);
    clr = 1'b0;
    check("rst_count",  32'(count), 32'd0);
    check("rst_avail",  32'(data_avail), 32'd0);
    check("rst_full",   32'(full), 32'd0);
    check("rst_ovf",    32'(overflow), 32'd0);
    check("rst_data",   InPortData, 32'h0);
    ticks(3);

    // Basic capture: visible exactly on the 3rd edge after the rise
    dev_data   = 32'hA5A5_0001;
    dev_strobe = 1'b1;
    exp_q.push_back(32'hA5A5_0001);
    ticks(2);
    check("cap_count_early", 32'(count), 32'd0);
    tick();
    check("cap_count", 32'(count), 32'd1);
    check("cap_avail", 32'(data_avail), 32'd1);
    check("cap_data",  InPortData, 32'hA5A5_0001);
    dev_strobe = 1'b0;
    ticks(2);
    pop();
    check("pop_count", 32'(count), 32'd0);
    check("pop_last",  InPortData, 32'hA5A5_0001);

    // Fill and overflow
    for (int i = 0; i < 4; i++) dev_write(32'h10 + 32'(i), 1'b1);
    check("fill_full",  32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    dev_write(32'h14, 1'b0);
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Push and pop on the same edge while full
    write_with(32'h20, 1'b1, 1'b1, 1'b0);
    check("pp_full_count", 32'(count), 32'd4);
    check("pp_full_ovf",   32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) pop();
    check("drain_count", 32'(count), 32'd0);
    check("drain_last",  InPortData, 32'h20);

    // Wrap-around with 2..3 words outstanding
    dev_write(32'h100, 1'b1);
    dev_write(32'h101, 1'b1);
    for (int i = 0; i < 10; i++) begin
      dev_write(32'h102 + 32'(i), 1'b1);
      check("wrap_count_hi", 32'(count), 32'd3);
      pop();
      check("wrap_count_lo", 32'(count), 32'd2);
    end
    pop();
    pop();
    check("wrap_empty", 32'(count), 32'd0);
    check("wrap_last",  InPortData, 32'h10B);

    // Pop on empty while a push lands: the new word stays queued
    write_with(32'h77, 1'b1, 1'b1, 1'b0);
    check("ep_count", 32'(count), 32'd1);
    check("ep_data",  InPortData, 32'h77);

    // Reset with 2 words queued
    dev_write(32'h78, 1'b1);
    check("pre_clr_count", 32'(count), 32'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
    check("clr_count", 32'(count), 32'd0);
    check("clr_data",  InPortData, 32'h0);
    ticks(3);

    // Strobe held high through reset release: no push
    dev_data   = 32'h99;
    dev_strobe = 1'b1;
    clr        = 1'b1;
    ticks(2);
    clr = 1'b0;
    ticks(5);
    check("held_strobe_count", 32'(count), 32'd0);
    dev_strobe = 1'b0;
    ticks(2);
    dev_write(32'h55, 1'b1);
    check("after_held_count", 32'(count), 32'd1);
    pop();

    // ovf_clr coincident with a drop: set wins
    for (int i = 0; i < 4; i++) dev_write(32'h30 + 32'(i), 1'b1);
    check("ovf2_full", 32'(full), 32'd1);
    write_with(32'h34, 1'b0, 1'b0, 1'b1);
    check("ovf_set_wins", 32'(overflow), 32'd1);
    check("ovf2_count",   32'(count), 32'd4);
    for (int i = 0; i < 4; i++) pop();
    check("ovf2_drain", 32'(count), 32'd0);

    check("queue_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
